// File: rtl/ahb_sram_slave.sv
`default_nettype none
// ============================================================================
// Module      : ahb_sram_slave
// Description : AHB-Lite slave over a word-addressed register memory.
//               Byte/halfword/word writes with lane masking, full-word
//               reads, configurable wait states and a two-cycle ERROR
//               response for misaligned or oversized transfers.
// Revision    : 1.0 - initial release
// ============================================================================
module ahb_sram_slave #(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 32,
    parameter int WAIT_STATES = 0
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [DATA_WIDTH-1:0] HRDATA
);

    localparam int         c_DEPTH     = 2 ** (ADDR_WIDTH - 2);
    localparam int         c_LANES     = DATA_WIDTH / 8;
    localparam bit         c_HAS_WAIT  = (WAIT_STATES > 0);
    localparam logic [3:0] c_WAIT_LOAD = c_HAS_WAIT ? 4'(WAIT_STATES - 1) : 4'd0;

    localparam logic [2:0] c_ST_IDLE = 3'd0;
    localparam logic [2:0] c_ST_WAIT = 3'd1;
    localparam logic [2:0] c_ST_DATA = 3'd2;
    localparam logic [2:0] c_ST_ERR1 = 3'd3;
    localparam logic [2:0] c_ST_ERR2 = 3'd4;

    logic [2:0]            r_state;
    logic [2:0]            w_next_state;
    logic [3:0]            r_wait_cnt;
    logic [ADDR_WIDTH-3:0] r_idx;
    logic [1:0]            r_off;
    logic [1:0]            r_size;
    logic                  r_write;
    logic [DATA_WIDTH-1:0] r_mem [0:c_DEPTH-1];

    logic                  w_ready;
    logic                  w_accept;
    logic                  w_illegal;
    logic                  w_commit;
    logic [c_LANES-1:0]    w_lane_mask;
    logic                  w_unused_ok;

    // Burst type is informational only; every beat carries its own address.
    assign w_unused_ok = &{1'b0, HBURST, HTRANS[0]};

    // Only WAIT and ERR1 stall the bus; a new address phase is taken only
    // while this slave is itself ready.
    assign w_ready   = (r_state != c_ST_WAIT) && (r_state != c_ST_ERR1);
    assign w_accept  = HSEL & HTRANS[1] & HREADY & w_ready;
    assign w_illegal = (HSIZE > 3'd2)
                     | ((HSIZE == 3'd1) & HADDR[0])
                     | ((HSIZE == 3'd2) & (HADDR[1:0] != 2'b00));

    assign HREADYOUT = w_ready;
    assign HRESP     = (r_state == c_ST_ERR1) || (r_state == c_ST_ERR2);
    assign HRDATA    = (r_state == c_ST_DATA) ? r_mem[r_idx] : '0;

    // State register.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode; DATA and ERR2 can chain straight into a new transfer.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE, c_ST_DATA, c_ST_ERR2: begin
                if (w_accept) begin
                    if (w_illegal) begin
                        w_next_state = c_ST_ERR1;
                    end else if (c_HAS_WAIT) begin
                        w_next_state = c_ST_WAIT;
                    end else begin
                        w_next_state = c_ST_DATA;
                    end
                end else begin
                    w_next_state = c_ST_IDLE;
                end
            end
            c_ST_WAIT: begin
                if (r_wait_cnt == 4'd0) begin
                    w_next_state = c_ST_DATA;
                end
            end
            c_ST_ERR1: w_next_state = c_ST_ERR2;
            default:   w_next_state = c_ST_IDLE;
        endcase
    end

    // Wait counter: loaded on a legal accept, counts down through WAIT.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_wait_cnt <= 4'd0;
        end else if (w_accept && !w_illegal && c_HAS_WAIT) begin
            r_wait_cnt <= c_WAIT_LOAD;
        end else if ((r_state == c_ST_WAIT) && (r_wait_cnt != 4'd0)) begin
            r_wait_cnt <= r_wait_cnt - 4'd1;
        end
    end

    // Address-phase capture for the following data phase.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_idx   <= '0;
            r_off   <= 2'b00;
            r_size  <= 2'b00;
            r_write <= 1'b0;
        end else if (w_accept) begin
            r_idx   <= HADDR[ADDR_WIDTH-1:2];
            r_off   <= HADDR[1:0];
            r_size  <= HSIZE[1:0];
            r_write <= HWRITE;
        end
    end

    // Byte-lane enables from the captured size and offset.
    always_comb begin
        w_lane_mask = 4'b1111;
        case (r_size)
            2'd0:    w_lane_mask = 4'b0001 << r_off;
            2'd1:    w_lane_mask = r_off[1] ? 4'b1100 : 4'b0011;
            default: w_lane_mask = 4'b1111;
        endcase
    end

    // A write lands at the edge closing DATA, unless reset drops it.
    assign w_commit = (r_state == c_ST_DATA) && r_write && !ARESET;

    // Storage array; contents survive reset by design.
    always_ff @(posedge ACLK) begin
        if (w_commit) begin
            for (int i = 0; i < c_LANES; i++) begin
                if (w_lane_mask[i]) begin
                    r_mem[r_idx][8*i +: 8] <= HWDATA[8*i +: 8];
                end
            end
        end
    end

endmodule
`default_nettype wire
